// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants and types for the 4-digit seven-segment scanner.
//   NUM_DIGITS : number of multiplexed digits
//   SEG_0..F   : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_OFF    : all segments dark
//   disp_t     : one frame's worth of digit data (value, decimal points, blanks)
//   anode_sel  : active-low one-hot anode select for a digit index
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    anode_sel = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode -- combinational hex digit to seven-segment pattern.
//   hex : 4-bit digit value
//   seg : active-low pattern {g,f,e,d,c,b,a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // hex to segment lookup
  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan -- multiplexed 4-digit seven-segment driver with tear-free updates.
// New data is staged with a one-cycle load and committed to the display
// registers only at the end of a full scan frame, so a frame never shows a
// mix of old and new digits.
//   clk     : system clock (posedge)
//   rst     : synchronous active-high reset
//   value   : four hex digits, value[3:0] is digit 0 (rightmost)
//   dp      : per-digit decimal point enable
//   blank   : per-digit blank request
//   load    : one-cycle stage request for value/dp/blank (and blink)
//   blink   : per-digit blink enable (only when SEG7_BLINK_EN is defined)
//   pending : staged data waiting for the next frame end
//   done    : one-cycle pulse when staged data reaches the display
//   an      : active-low anodes
//   seg     : active-low segments {g,f,e,d,c,b,a}
//   dp_n    : active-low decimal point
// Optional feature macro: SEG7_BLINK_EN (adds blink input, frame counter and
// blink phase; BLINK_FRAMES frames per half-period).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV          = 25000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic        load,
`ifdef SEG7_BLINK_EN
  input  logic [3:0]  blink,
`endif
  output logic        pending,
  output logic        done,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  localparam logic [15:0]      DIV_LAST = 16'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [15:0]      div_cnt;
  logic [IDX_W-1:0] idx;
  logic             frame_end;
  logic             commit;

  disp_t stage;
  disp_t disp;

  logic [3:0] digit;
  logic [6:0] dec_seg;
  logic       dp_bit;
  logic       dark;
  logic       blink_dark;

  assign frame_end = (idx == IDX_LAST) && (div_cnt == DIV_LAST);
  // Commit uses the pending flag as it stood before any same-cycle load, so a
  // load on the frame-end cycle commits the older staged data first.
  assign commit    = frame_end && pending;

  // digit-time divider and scan index
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= 16'd0;
      idx     <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= 16'd0;
      idx     <= idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // staging registers and pending flag; the last load before a commit wins
  always_ff @(posedge clk) begin
    if (rst) begin
      stage   <= '0;
      pending <= 1'b0;
    end else if (load) begin
      stage.value <= value;
      stage.dp    <= dp;
      stage.blank <= blank;
      pending     <= 1'b1;
    end else if (commit) begin
      pending <= 1'b0;
    end else begin
      pending <= pending;
    end
  end

  // display registers, only ever updated at a frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= '0;
      done <= 1'b0;
    end else begin
      done <= commit;
      if (commit) begin
        disp <= stage;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [3:0]    stage_blink;
  logic [3:0]    disp_blink;
  logic [FW-1:0] frame_cnt;
  logic          phase;

  // blink enables follow the same stage/commit path as the digit data
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_blink <= 4'd0;
      disp_blink  <= 4'd0;
    end else begin
      if (load) begin
        stage_blink <= blink;
      end
      if (commit) begin
        disp_blink <= stage_blink;
      end
    end
  end

  // frame counter; phase flips every BLINK_FRAMES frames
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_dark = phase & disp_blink[idx];
`else
  assign blink_dark = 1'b0;
`endif

  // select the display data for the digit currently being scanned
  always_comb begin
    digit  = disp.value[{idx, 2'b00} +: 4];
    dp_bit = disp.dp[idx];
    dark   = disp.blank[idx] | blink_dark;
  end

  seg7_decode u_decode (
    .hex (digit),
    .seg (dec_seg)
  );

  // registered pin drivers, one cycle behind idx
  always_ff @(posedge clk) begin
    if (rst) begin
      an   <= 4'b1111;
      seg  <= SEG_OFF;
      dp_n <= 1'b1;
    end else if (dark) begin
      an   <= 4'b1111;
      seg  <= SEG_OFF;
      dp_n <= 1'b1;
    end else begin
      an   <= anode_sel(idx);
      seg  <= dec_seg;
      dp_n <= ~dp_bit;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan -- randomized self-checking bench for seg7_scan (DIV=4,
// BLINK_FRAMES=2). A cycle-level reference model derives digit position from
// elapsed cycles since reset and tracks staged/displayed frames as plain data.
// Define SEG7_BLINK_EN to exercise the blink feature.
module tb_seg7_scan;

  localparam int DIV   = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic        load;
  logic        pending;
  logic        done;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  seg7_scan #(.DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk     (clk),
    .rst     (rst),
    .value   (value),
    .dp      (dp),
    .blank   (blank),
    .load    (load),
`ifdef SEG7_BLINK_EN
    .blink   (blink),
`endif
    .pending (pending),
    .done    (done),
    .an      (an),
    .seg     (seg),
    .dp_n    (dp_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  // reference model state
  int          m_c;
  int          m_frames;
  bit          m_pend;
  logic [15:0] m_sval, m_dval;
  logic [3:0]  m_sdp, m_ddp, m_sblank, m_dblank, m_sblink, m_dblink;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dpn, e_done, e_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // advance the model over one clock edge using the current inputs
  task model_step();
    int          ix;
    bit          fe, ph, dk;
    logic [15:0] nib;
    if (rst) begin
      m_c = 0; m_frames = 0; m_pend = 0;
      m_sval = '0; m_dval = '0; m_sdp = '0; m_ddp = '0;
      m_sblank = '0; m_dblank = '0; m_sblink = '0; m_dblink = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_done = 1'b0; e_pend = 1'b0;
    end else begin
      ix = (m_c / DIV) % 4;
      fe = (m_c % FRAME) == FRAME - 1;
`ifdef SEG7_BLINK_EN
      ph = ((m_frames / BF) % 2) == 1;
`else
      ph = 1'b0;
`endif
      dk  = m_dblank[ix] | (ph & m_dblink[ix]);
      nib = (m_dval >> (4 * ix)) & 16'h000F;
      e_an  = dk ? 4'hF : ~(4'b0001 << ix);
      e_seg = dk ? 7'h7F : hex_ref[nib[3:0]];
      e_dpn = dk ? 1'b1 : ~m_ddp[ix];
      e_done = fe && m_pend;
      if (e_done) begin
        m_dval = m_sval; m_ddp = m_sdp; m_dblank = m_sblank; m_dblink = m_sblink;
      end
      if (load) begin
        m_sval = value; m_sdp = dp; m_sblank = blank; m_sblink = blink;
      end
      m_pend = load | (m_pend & !fe);
      e_pend = m_pend;
      if (fe) m_frames++;
      m_c++;
    end
  endtask

  task automatic step(input bit r, input bit ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] b, input logic [3:0] bk);
    rst = r; load = ld; value = v; dp = d; blank = b; blink = bk;
    @(posedge clk);
    model_step();
    #1;
    check_eq("an", an, e_an);
    check_eq("seg", seg, e_seg);
    check_eq("dp_n", dp_n, e_dpn);
    check_eq("done", done, e_done);
    check_eq("pending", pending, e_pend);
    if (done === 1'b1) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  // idle until the next edge lands on frame position pos (bounded by one frame)
  task automatic idle_until(input int pos);
    for (int i = 0; i < FRAME && (m_c % FRAME) != pos; i++) idle(1);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp = '0; blank = '0; blink = '0;
    m_c = 0;

    // reset, then idle display of zeros
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    idle(2 * FRAME);

    // load mid-frame with digit 0 decimal point
    idle_until(6);
    step(1'b0, 1'b1, 16'h1234, 4'b0001, 4'b0000, 4'b0000);
    idle(2 * FRAME);

    // two loads within one frame: last wins, one done pulse
    idle_until(2);
    done_seen = 0;
    step(1'b0, 1'b1, 16'hAAAA, 4'b0000, 4'b0000, 4'b0000);
    idle(3);
    step(1'b0, 1'b1, 16'h5555, 4'b0000, 4'b0000, 4'b0000);
    idle(FRAME);
    check_eq("done_count", done_seen, 1);

    // load on the frame-end cycle while pending
    idle_until(3);
    step(1'b0, 1'b1, 16'hBEEF, 4'b0010, 4'b0000, 4'b0000);
    idle_until(FRAME - 1);
    step(1'b0, 1'b1, 16'hC0DE, 4'b0100, 4'b0000, 4'b0000);
    check_eq("pend_after_fe_load", pending, 1);
    idle(2 * FRAME);

    // load on the frame-end cycle while idle
    idle_until(FRAME - 1);
    step(1'b0, 1'b1, 16'h8F01, 4'b1000, 4'b0000, 4'b0000);
    idle(2 * FRAME);

    // blank the leftmost digit
    step(1'b0, 1'b1, 16'h9876, 4'b1111, 4'b1000, 4'b0000);
    idle(2 * FRAME);

    // reset mid-frame with a load pending
    step(1'b0, 1'b1, 16'h4321, 4'b0011, 4'b0000, 4'b0000);
    idle_until(7);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    check_eq("rst_pending", pending, 0);
    idle(2 * FRAME);

    // blink digit 0
    step(1'b0, 1'b1, 16'h00F8, 4'b0000, 4'b0000, 4'b0001);
    idle(6 * FRAME);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
           16'($urandom), 4'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
           4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
